// File: rtl/axi4_mem_slave.sv
// rtl/axi4_mem_slave.sv - AXI4 responder over a word-wide synchronous RAM, single and burst access.
// Define AXI4_MEM_SLAVE_DECERR_EN to reject out-of-range transactions with DECERR.
module axi4_mem_slave #(
   parameter int ADDR_W     = 10,
   parameter int RESP_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inport_awvalid_i,
   input  logic [31:0] inport_awaddr_i,
   input  logic [3:0]  inport_awid_i,
   input  logic [7:0]  inport_awlen_i,
   input  logic [1:0]  inport_awburst_i,
   output logic        inport_awready_o,
   input  logic        inport_wvalid_i,
   input  logic [31:0] inport_wdata_i,
   input  logic [3:0]  inport_wstrb_i,
   input  logic        inport_wlast_i,
   output logic        inport_wready_o,
   output logic        inport_bvalid_o,
   output logic [1:0]  inport_bresp_o,
   output logic [3:0]  inport_bid_o,
   input  logic        inport_bready_i,
   input  logic        inport_arvalid_i,
   input  logic [31:0] inport_araddr_i,
   input  logic [3:0]  inport_arid_i,
   input  logic [7:0]  inport_arlen_i,
   input  logic [1:0]  inport_arburst_i,
   output logic        inport_arready_o,
   output logic        inport_rvalid_o,
   output logic [31:0] inport_rdata_o,
   output logic [1:0]  inport_rresp_o,
   output logic [3:0]  inport_rid_o,
   output logic        inport_rlast_o,
   input  logic        inport_rready_i
);

   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_t;
   state_t state_q, state_d;

   logic              prio_rd_q;
   logic [3:0]        id_q;
   logic [7:0]        len_q;
   logic [7:0]        cnt_q;
   logic [1:0]        burst_q;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;
   logic              rd_remain_q;

   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic [31:0]       mem_rdata_q;
   logic              inflight_q;
   logic              inflight_last_q;

   logic [31:0]           fifo_data [0:RESP_DEPTH-1];
   logic [RESP_DEPTH-1:0] fifo_last;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;

   logic        grant_wr;
   logic        aw_accept;
   logic        ar_accept;
   logic        w_beat;
   logic        r_valid;
   logic        r_pop;
   logic        rd_issue;
   logic [31:0] acc_addr;
   logic [3:0]  acc_id;
   logic [7:0]  acc_len;
   logic [1:0]  acc_burst;
   logic        acc_err;
   logic        unused_bits;

   // FIXED holds, WRAP on 2/4/8/16 beats wraps the low bits, everything else increments.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0] burst,
                                                   input logic [7:0] len);
      logic [ADDR_W-1:0] inc;
      logic [ADDR_W-1:0] mask;
      inc  = a + ADDR_W'(1);
      mask = ADDR_W'(len);
      if (burst == 2'd0)
         return a;
      if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         return (a & ~mask) | (inc & mask);
      return inc;
   endfunction

   // Round-robin: when both request, the channel not granted last time wins.
   assign grant_wr  = inport_awvalid_i && (!inport_arvalid_i || !prio_rd_q);
   assign aw_accept = rst_i && state_q == S_IDLE && grant_wr;
   assign ar_accept = rst_i && state_q == S_IDLE && inport_arvalid_i && !grant_wr;
   assign w_beat    = state_q == S_WRITE && inport_wvalid_i;

   assign acc_addr  = grant_wr ? inport_awaddr_i  : inport_araddr_i;
   assign acc_id    = grant_wr ? inport_awid_i    : inport_arid_i;
   assign acc_len   = grant_wr ? inport_awlen_i   : inport_arlen_i;
   assign acc_burst = grant_wr ? inport_awburst_i : inport_arburst_i;

`ifdef AXI4_MEM_SLAVE_DECERR_EN
   assign acc_err     = |acc_addr[31:ADDR_W+2];
   assign unused_bits = ^{acc_addr[1:0], inport_wlast_i};
`else
   assign acc_err     = 1'b0;
   assign unused_bits = ^{acc_addr[1:0], acc_addr[31:ADDR_W+2], inport_wlast_i};
`endif

   assign r_valid  = count_q != '0;
   assign r_pop    = r_valid && inport_rready_i;
   // A same-cycle pop frees a slot, which keeps one beat per cycle with a 2-entry buffer.
   assign rd_issue = state_q == S_READ && rd_remain_q &&
                     (((count_q + CNT_W'(inflight_q)) < CNT_W'(RESP_DEPTH)) || r_pop);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (aw_accept)
               state_d = S_WRITE;
            else if (ar_accept)
               state_d = S_READ;
         end
         S_WRITE: if (w_beat && cnt_q == 8'd0) state_d = S_WRESP;
         S_WRESP: if (inport_bready_i) state_d = S_IDLE;
         S_READ:  if (r_pop && fifo_last[rd_ptr_q]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q         <= S_IDLE;
         prio_rd_q       <= 1'b0;
         id_q            <= '0;
         len_q           <= '0;
         cnt_q           <= '0;
         burst_q         <= '0;
         addr_q          <= '0;
         err_q           <= 1'b0;
         rd_remain_q     <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
      end else begin
         state_q <= state_d;
         if (aw_accept || ar_accept) begin
            prio_rd_q   <= aw_accept;
            id_q        <= acc_id;
            len_q       <= acc_len;
            cnt_q       <= acc_len;
            burst_q     <= acc_burst;
            addr_q      <= acc_addr[ADDR_W+1:2];
            err_q       <= acc_err;
            rd_remain_q <= ar_accept;
         end
         if (w_beat || rd_issue) begin
            addr_q <= next_addr(addr_q, burst_q, len_q);
            cnt_q  <= cnt_q - 8'd1;
         end
         if (rd_issue && cnt_q == 8'd0)
            rd_remain_q <= 1'b0;
         inflight_q      <= rd_issue;
         inflight_last_q <= rd_issue && cnt_q == 8'd0;
         if (inflight_q)
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (r_pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({inflight_q, r_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_beat && !err_q) begin
         for (int b = 0; b < 4; b++) begin
            if (inport_wstrb_i[b])
               mem[addr_q][8*b +: 8] <= inport_wdata_i[8*b +: 8];
         end
      end
      if (rd_issue)
         mem_rdata_q <= mem[addr_q];
   end

   always_ff @(posedge clk_i) begin
      if (inflight_q) begin
         fifo_data[wr_ptr_q] <= err_q ? 32'd0 : mem_rdata_q;
         fifo_last[wr_ptr_q] <= inflight_last_q;
      end
   end

   assign inport_awready_o = aw_accept;
   assign inport_arready_o = ar_accept;
   assign inport_wready_o  = state_q == S_WRITE;
   assign inport_bvalid_o  = state_q == S_WRESP;
   assign inport_bresp_o   = (inport_bvalid_o && err_q) ? 2'b11 : 2'b00;
   assign inport_bid_o     = id_q;
   assign inport_rvalid_o  = r_valid;
   assign inport_rdata_o   = r_valid ? fifo_data[rd_ptr_q] : 32'd0;
   assign inport_rlast_o   = r_valid && fifo_last[rd_ptr_q];
   assign inport_rresp_o   = (r_valid && err_q) ? 2'b11 : 2'b00;
   assign inport_rid_o     = id_q;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb/tb_axi4_mem_slave.sv - directed self-checking bench for axi4_mem_slave with response scoreboard.
`timescale 1ns/1ps
module tb_axi4_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [3:0]  awid, arid, wstrb, bid, rid;
   logic [7:0]  awlen, arlen;
   logic [1:0]  awburst, arburst, bresp, rresp;

   always #5 clk = ~clk;

   axi4_mem_slave #(.ADDR_W(10), .RESP_DEPTH(2)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .inport_awvalid_i(awvalid), .inport_awaddr_i(awaddr), .inport_awid_i(awid),
      .inport_awlen_i(awlen), .inport_awburst_i(awburst), .inport_awready_o(awready),
      .inport_wvalid_i(wvalid), .inport_wdata_i(wdata), .inport_wstrb_i(wstrb),
      .inport_wlast_i(wlast), .inport_wready_o(wready),
      .inport_bvalid_o(bvalid), .inport_bresp_o(bresp), .inport_bid_o(bid), .inport_bready_i(bready),
      .inport_arvalid_i(arvalid), .inport_araddr_i(araddr), .inport_arid_i(arid),
      .inport_arlen_i(arlen), .inport_arburst_i(arburst), .inport_arready_o(arready),
      .inport_rvalid_o(rvalid), .inport_rdata_o(rdata), .inport_rresp_o(rresp),
      .inport_rid_o(rid), .inport_rlast_o(rlast), .inport_rready_i(rready)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [3:0]  id;
      logic [1:0]  resp;
   } r_exp_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   r_exp_t r_exp_q[$];
   b_exp_t b_exp_q[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic exp_r(input logic [31:0] d, input logic l, input logic [3:0] id, input logic [1:0] resp);
      r_exp_t e;
      e.data = d;
      e.last = l;
      e.id   = id;
      e.resp = resp;
      r_exp_q.push_back(e);
   endtask

   task automatic aw_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [1:0] resp);
      b_exp_t e;
      int     n = 0;
      e.id   = id;
      e.resp = resp;
      b_exp_q.push_back(e);
      awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
      #1;
      while (!awready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      check("aw_accept", awready, 1);
      @(negedge clk);
      awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      #1;
      while (!wready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      check("w_accept", wready, 1);
      @(negedge clk);
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic b_recv(input int hold);
      b_exp_t e;
      int     n = 0;
      bready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         #1;
         check("bvalid_hold", bvalid, 1);
         check("ar_blocked_in_wresp", arready, 0);
         @(negedge clk);
      end
      bready = 1'b1;
      #1;
      while (!bvalid && n < 100) begin
         @(negedge clk); #1; n++;
      end
      check("bvalid", bvalid, 1);
      check("b_exp_pending", b_exp_q.size() > 0, 1);
      e = (b_exp_q.size() > 0) ? b_exp_q.pop_front() : '0;
      check("bid", bid, e.id);
      check("bresp", bresp, e.resp);
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst);
      int n = 0;
      araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
      #1;
      while (!arready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      check("ar_accept", arready, 1);
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   task automatic r_recv(input int n, output int cycles);
      r_exp_t e;
      int     got = 0;
      cycles = 0;
      rready = 1'b1;
      while (got < n && cycles < 200) begin
         #1;
         if (rvalid) begin
            check("r_exp_pending", r_exp_q.size() > 0, 1);
            e = (r_exp_q.size() > 0) ? r_exp_q.pop_front() : '0;
            check("rdata", rdata, e.data);
            check("rlast", rlast, e.last);
            check("rid", rid, e.id);
            check("rresp", rresp, e.resp);
            got++;
         end
         cycles++;
         @(negedge clk);
      end
      rready = 1'b0;
      check("r_beat_count", got, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      awaddr = '0; awid = '0; awlen = '0; awburst = 2'd1; wdata = '0; wstrb = '0; wlast = 1'b0;
      araddr = '0; arid = '0; arlen = '0; arburst = 2'd1;

      // Reset: valid requests present but nothing may be ready.
      repeat (3) @(negedge clk);
      #1;
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rlast", rlast, 0);
      check("rst_ids", {bid, rid, bresp, rresp}, 0);
      awvalid = 1'b0; arvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single write then read with latency checks.
      aw_send(32'h10, 4'd3, 8'd0, 2'd1, 2'b00);
      w_send(32'hDEADBEEF, 4'hF, 1'b1);
      #1;
      check("b_latency", bvalid, 1);
      b_recv(0);
      exp_r(32'hDEADBEEF, 1'b1, 4'd3, 2'b00);
      ar_send(32'h10, 4'd3, 8'd0, 2'd1);
      #1;
      check("r_latency_c0", rvalid, 0);
      @(negedge clk); #1;
      check("r_latency_c1", rvalid, 0);
      @(negedge clk); #1;
      check("r_latency_c2", rvalid, 1);
      r_recv(1, cyc);

      // INCR burst, read data stalled for five cycles.
      aw_send(32'h100, 4'd1, 8'd3, 2'd1, 2'b00);
      for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, i == 3);
      b_recv(0);
      for (int i = 0; i < 4; i++) exp_r(32'(i + 1), i == 3, 4'd2, 2'b00);
      ar_send(32'h100, 4'd2, 8'd3, 2'd1);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk); #1;
         if (i >= 2) begin
            check("stall_rvalid", rvalid, 1);
            check("stall_rdata", rdata, 32'd1);
         end
      end
      r_recv(4, cyc);
      check("stall_consecutive", cyc, 4);

      // WRAP burst written, read back linearly.
      aw_send(32'h28, 4'd4, 8'd3, 2'd2, 2'b00);
      for (int i = 0; i < 4; i++) w_send(32'hA + 32'(i), 4'hF, i == 3);
      b_recv(0);
      exp_r(32'hC, 1'b0, 4'd4, 2'b00);
      exp_r(32'hD, 1'b0, 4'd4, 2'b00);
      exp_r(32'hA, 1'b0, 4'd4, 2'b00);
      exp_r(32'hB, 1'b1, 4'd4, 2'b00);
      ar_send(32'h20, 4'd4, 8'd3, 2'd1);
      r_recv(4, cyc);

      // Byte strobes.
      aw_send(32'h40, 4'd5, 8'd0, 2'd1, 2'b00);
      w_send(32'hFFFFFFFF, 4'hF, 1'b1);
      b_recv(0);
      aw_send(32'h40, 4'd5, 8'd0, 2'd1, 2'b00);
      w_send(32'h00000000, 4'h5, 1'b1);
      b_recv(0);
      exp_r(32'hFF00FF00, 1'b1, 4'd5, 2'b00);
      ar_send(32'h40, 4'd5, 8'd0, 2'd1);
      r_recv(1, cyc);

      // FIXED burst: both beats land on the same word.
      aw_send(32'h80, 4'd6, 8'd1, 2'd0, 2'b00);
      w_send(32'd7, 4'hF, 1'b0);
      w_send(32'd8, 4'hF, 1'b1);
      b_recv(0);
      exp_r(32'd8, 1'b1, 4'd6, 2'b00);
      ar_send(32'h80, 4'd6, 8'd0, 2'd1);
      r_recv(1, cyc);

      // Arbitration: write first, then read; bready low blocks AR.
      awaddr = 32'h200; awid = 4'd7; awlen = 8'd0; awburst = 2'd1;
      araddr = 32'h200; arid = 4'd8; arlen = 8'd0; arburst = 2'd1;
      b_exp_q.push_back(b_exp_t'({4'd7, 2'b00}));
      awvalid = 1'b1; arvalid = 1'b1;
      #1;
      check("arb1_awready", awready, 1);
      check("arb1_arready", arready, 0);
      @(negedge clk);
      awvalid = 1'b0;
      #1;
      check("arb_ar_blocked_in_write", arready, 0);
      w_send(32'h12345678, 4'hF, 1'b1);
      b_recv(10);
      awaddr = 32'h300; awvalid = 1'b1;
      #1;
      check("arb2_arready", arready, 1);
      check("arb2_awready", awready, 0);
      exp_r(32'h12345678, 1'b1, 4'd8, 2'b00);
      @(negedge clk);
      awvalid = 1'b0; arvalid = 1'b0;
      r_recv(1, cyc);

      // INCR wrap past the top word to word 0.
      aw_send(32'hFFC, 4'd9, 8'd1, 2'd1, 2'b00);
      w_send(32'h11111111, 4'hF, 1'b0);
      w_send(32'h22222222, 4'hF, 1'b1);
      b_recv(0);
      exp_r(32'h11111111, 1'b0, 4'd9, 2'b00);
      exp_r(32'h22222222, 1'b1, 4'd9, 2'b00);
      ar_send(32'hFFC, 4'd9, 8'd1, 2'd1);
      r_recv(2, cyc);
      exp_r(32'h22222222, 1'b1, 4'd9, 2'b00);
      ar_send(32'h0, 4'd9, 8'd0, 2'd1);
      r_recv(1, cyc);

      // Out-of-range start address.
`ifdef AXI4_MEM_SLAVE_DECERR_EN
      aw_send(32'h1000, 4'd10, 8'd0, 2'd1, 2'b11);
      w_send(32'hBADBAD00, 4'hF, 1'b1);
      b_recv(0);
      exp_r(32'h0, 1'b0, 4'd10, 2'b11);
      exp_r(32'h0, 1'b1, 4'd10, 2'b11);
      ar_send(32'h1000, 4'd10, 8'd1, 2'd1);
      r_recv(2, cyc);
      exp_r(32'h22222222, 1'b1, 4'd10, 2'b00);
      ar_send(32'h0, 4'd10, 8'd0, 2'd1);
      r_recv(1, cyc);
`else
      exp_r(32'h22222222, 1'b1, 4'd10, 2'b00);
      ar_send(32'h1000, 4'd10, 8'd0, 2'd1);
      r_recv(1, cyc);
`endif

      check("r_queue_drained", r_exp_q.size(), 0);
      check("b_queue_drained", b_exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
